// File: rtl/jump_return_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module : jump_return_stack_pkg
// Brief  : Shared defaults and opcode-bit decode for the return-address stack.
// Rev    : 1.0
// ============================================================================
package jump_return_stack_pkg;

  localparam int JRS_WIDTH_DEF = 16;
  localparam int JRS_DEPTH_DEF = 16;

  localparam int OP_JUMP_BIT  = 14;
  localparam int OP_STORE_BIT = 15;

  // Program-RAM opcode decode used where the stack is instantiated.
  function automatic logic jrs_decode_push(input logic [15:0] op_word);
    return op_word[OP_JUMP_BIT] & ~op_word[OP_STORE_BIT];
  endfunction

  function automatic logic jrs_decode_pop(input logic [15:0] op_word);
    return op_word[OP_JUMP_BIT] & op_word[OP_STORE_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/jump_return_stack_stack_mem.sv
`default_nettype none
// ============================================================================
// Module : stack_mem
// Brief  : DEPTH x WIDTH register array, one sync write port, async read port.
// Rev    : 1.0
// ============================================================================
module stack_mem
  import jump_return_stack_pkg::*;
#(
  parameter int WIDTH = JRS_WIDTH_DEF,
  parameter int DEPTH = JRS_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are deliberately left uninitialised; readers gate with occupancy.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/jump_return_stack.sv
`default_nettype none
// ============================================================================
// Module : jump_return_stack
// Brief  : LIFO return-address stack with replace-top and reject pulses.
// Rev    : 1.0
// ============================================================================
module jump_return_stack
  import jump_return_stack_pkg::*;
#(
  parameter int WIDTH = JRS_WIDTH_DEF,
  parameter int DEPTH = JRS_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dataout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_rdata;
  logic             w_empty;
  logic             w_full;

  assign w_empty   = (cnt_q == '0);
  assign w_full    = (cnt_q == CW'(DEPTH));
  // Low bits wrap to DEPTH-1 when full, which is exactly the top entry.
  assign w_top_idx = cnt_q[AW-1:0] - AW'(1);

  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    w_we    = 1'b0;
    w_waddr = cnt_q[AW-1:0];
    case ({push, pop})
      2'b10: begin
        if (!w_full) begin
          w_we  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (!w_empty) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          udf_d = 1'b1;
        end
      end
      2'b11: begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_waddr = w_top_idx;
        end else begin
          cnt_d = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_stack_mem (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i (datain),
    .raddr_i (w_top_idx),
    .rdata_o (w_rdata)
  );

  assign dataout   = w_empty ? '0 : w_rdata;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_return_stack.sv
`default_nettype none
// ============================================================================
// Module : tb_jump_return_stack
// Brief  : Directed self-checking bench for the return-address stack.
// Rev    : 1.0
// ============================================================================
module tb_jump_return_stack;

  logic        clk;
  logic        reset;
  logic [15:0] datain;
  logic        push;
  logic        pop;
  logic [15:0] dataout;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int vectors;
  int miscompares;

  jump_return_stack #(
    .WIDTH (16),
    .DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .datain    (datain),
    .push      (push),
    .pop       (pop),
    .dataout   (dataout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one request on the falling edge, then settle just after the rising edge.
  task automatic cycle(input logic p, input logic q, input logic [15:0] d);
    @(negedge clk);
    push   = p;
    pop    = q;
    datain = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 16'h0ABC);
    if (count !== 5'd1 || dataout !== 16'h0ABC) begin
      miscompares++;
      $display("FAIL pre_reset_push: count=%0d dataout=%h, want 1 / 0abc", count, dataout);
    end
    vectors++;
    @(negedge clk);
    push   = 1'b1;
    pop    = 1'b0;
    datain = 16'h1234;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (dataout !== 16'h0 || empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_immediate: dataout=%h empty=%b count=%0d full=%b, want 0/1/0/0",
               dataout, empty, count, full);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: count=%0d empty=%b ovf=%b udf=%b, want 0/1/0/0",
               count, empty, overflow, underflow);
    end
    @(negedge clk);
    push  = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_push_pop();
    logic [15:0] pv [3];
    logic [15:0] ev [3];
    pv = '{16'h0005, 16'h0012, 16'h00A3};
    ev = '{16'h0012, 16'h0005, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, pv[i]);
      vectors++;
      if (dataout !== pv[i] || count !== 5'(i + 1)) begin
        miscompares++;
        $display("FAIL push_%0d: dataout=%h count=%0d, want %h / %0d", i, dataout, count, pv[i], i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 16'h0);
      vectors++;
      if (dataout !== ev[i] || count !== 5'(2 - i)) begin
        miscompares++;
        $display("FAIL pop_%0d: dataout=%h count=%0d, want %h / %0d", i, dataout, count, ev[i], 2 - i);
      end
    end
    vectors++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_empty_flag: empty=%b udf=%b, want 1 / 0", empty, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 16'h1000 + 16'(i));
      vectors++;
      if (full !== (i == 15) || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_%0d: full=%b ovf=%b, want %b / 0", i, full, overflow, i == 15);
      end
    end
    vectors++;
    if (dataout !== 16'h100F || count !== 5'd16) begin
      miscompares++;
      $display("FAIL fill_top: dataout=%h count=%0d, want 100f / 16", dataout, count);
    end
    cycle(1'b1, 1'b0, 16'hFFFF);
    vectors++;
    if (overflow !== 1'b1 || dataout !== 16'h100F || count !== 5'd16) begin
      miscompares++;
      $display("FAIL overflow: ovf=%b dataout=%h count=%0d, want 1 / 100f / 16", overflow, dataout, count);
    end
    cycle(1'b0, 1'b0, 16'h0);
    vectors++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_clear: ovf=%b full=%b, want 0 / 1", overflow, full);
    end
    cycle(1'b1, 1'b1, 16'hBEEF);
    vectors++;
    if (overflow !== 1'b0 || dataout !== 16'hBEEF || count !== 5'd16) begin
      miscompares++;
      $display("FAIL replace_full: ovf=%b dataout=%h count=%0d, want 0 / beef / 16", overflow, dataout, count);
    end
    cycle(1'b0, 1'b1, 16'h0);
    vectors++;
    if (dataout !== 16'h100E || count !== 5'd15 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_from_full: dataout=%h count=%0d full=%b, want 100e / 15 / 0", dataout, count, full);
    end
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 16'h0);
    vectors++;
    if (empty !== 1'b1 || dataout !== 16'h0 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: empty=%b dataout=%h udf=%b, want 1 / 0 / 0", empty, dataout, underflow);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, 16'h0);
    vectors++;
    if (underflow !== 1'b1 || count !== 5'd0 || dataout !== 16'h0) begin
      miscompares++;
      $display("FAIL underflow: udf=%b count=%0d dataout=%h, want 1 / 0 / 0", underflow, count, dataout);
    end
    cycle(1'b0, 1'b0, 16'h0);
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_clear: udf=%b, want 0", underflow);
    end
  endtask

  task automatic test_replace();
    cycle(1'b1, 1'b0, 16'h0005);
    cycle(1'b1, 1'b0, 16'h0012);
    cycle(1'b1, 1'b1, 16'h0777);
    vectors++;
    if (dataout !== 16'h0777 || count !== 5'd2) begin
      miscompares++;
      $display("FAIL replace_top: dataout=%h count=%0d, want 0777 / 2", dataout, count);
    end
    cycle(1'b0, 1'b1, 16'h0);
    vectors++;
    if (dataout !== 16'h0005 || count !== 5'd1) begin
      miscompares++;
      $display("FAIL replace_below: dataout=%h count=%0d, want 0005 / 1", dataout, count);
    end
    cycle(1'b0, 1'b1, 16'h0);
    cycle(1'b1, 1'b1, 16'h0042);
    vectors++;
    if (dataout !== 16'h0042 || count !== 5'd1 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL replace_empty: dataout=%h count=%0d udf=%b, want 0042 / 1 / 0", dataout, count, underflow);
    end
    cycle(1'b0, 1'b1, 16'h0);
  endtask

  task automatic test_interleaved();
    logic        pv [6];
    logic        qv [6];
    logic [15:0] dv [6];
    logic [15:0] ev [6];
    pv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    qv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    dv = '{16'h0010, 16'h0020, 16'h0, 16'h0030, 16'h0, 16'h0};
    ev = '{16'h0010, 16'h0020, 16'h0010, 16'h0030, 16'h0010, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      cycle(pv[i], qv[i], dv[i]);
      vectors++;
      if (dataout !== ev[i]) begin
        miscompares++;
        $display("FAIL interleave_%0d: dataout=%h, want %h", i, dataout, ev[i]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    datain = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_push_pop();
    test_fill();
    test_underflow();
    test_replace();
    test_interleaved();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jump_return_stack.md
Name: jump_return_stack

Overview:
- LIFO return-address stack for the 1-bit microprocessor's jump/call/return mechanism.
- A jump/call pushes the return address, which is the program counter plus the condition bit. A return pops it.
- The top-of-stack value feeds the program counter load path.
- Sits beside the accumulator/preset flip-flops in the processor core; driven by opcode bits 14/15 of the program RAM word.

Parameters:
- WIDTH, 16, bit width of each stored address.
- DEPTH, 16, number of entries; must be a power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- datain  input  WIDTH  value to push (return address).
- push  input  1  push request, sampled on rising clk.
- pop  input  1  pop request, sampled on rising clk.
- dataout  output  WIDTH  current top-of-stack; 0 when empty.
- empty  output  1  high when no entries are held.
- full  output  1  high when DEPTH entries are held.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- overflow  output  1  one-cycle pulse: push rejected because full.
- underflow  output  1  one-cycle pulse: pop rejected because empty.

Behaviour:
- State: entry array mem[DEPTH], occupancy counter cnt (0..DEPTH), registered overflow/underflow flags.
- Reset (reset=0, asynchronous):
  - cnt=0; overflow=0; underflow=0.
  - Array contents are not cleared.
  - Outputs immediately read dataout=0, empty=1, full=0, count=0. They hold these values while reset is low, regardless of clk.
- All updates below occur on rising clk edges while reset=1.
- push=1, pop=0:
  - If cnt<DEPTH: mem[cnt]<=datain, cnt<=cnt+1.
  - If full: no state change; overflow<=1.
- pop=1, push=0:
  - If cnt>0: cnt<=cnt-1. The popped entry's data is not erased.
  - If empty: no change; underflow<=1.
- push=1 and pop=1 (replace top):
  - If cnt>0: mem[cnt-1]<=datain, cnt unchanged.
  - If empty: behaves as a plain push (cnt becomes 1); no underflow.
  - Never raises overflow.
- Neither request asserted: state holds.
- overflow and underflow are registered and high for exactly the one cycle following the offending edge. They clear on the next edge unless the condition repeats.
- Output derivation:
  - dataout = mem[cnt-1] when cnt>0, else 0. Combinational from registered state, so a value pushed at edge N appears on dataout immediately after edge N (zero-cycle read latency after the write edge).
  - empty = (cnt==0); full = (cnt==DEPTH); count = cnt.
- Arithmetic: no wrap-around. cnt saturates at 0 and DEPTH via the reject rules above. datain is stored verbatim; the +condition addition is done by the caller.
- Reset mid-operation: any pending push/pop in the same cycle is discarded. After reset release the first rising edge is a normal operation.
- No X on any output after reset, including reads of never-written entries (gated to 0 by empty).

Decomposition:
- Shared package: WIDTH/DEPTH defaults and an opcode-bit constant pair (OP_JUMP_BIT=14, OP_STORE_BIT=15) used to derive push = b14&~b15 and pop = b14&b15 at the instantiation site.
- One natural sub-module: stack_mem, a DEPTH x WIDTH register array with a write port (addr, data, we) and an asynchronous read port.
- Pointer/flag control stays in jump_return_stack.

Test Plan:
- Reset: drive reset=0 mid-cycle with push=1 -> dataout=0, empty=1, count=0 immediately; no push occurs.
- Push 0x0005, 0x0012, 0x00A3 on three edges -> dataout 0x0005, 0x0012, 0x00A3 after each edge; count=3. Then three pops -> dataout 0x0012, 0x0005, 0x0000; empty=1.
- Fill: 16 pushes of 0x1000+i -> full=1, dataout=0x100F. 17th push of 0xFFFF -> overflow=1 for one cycle, dataout stays 0x100F, count=16.
- Pop when empty -> underflow=1 for one cycle; count=0; dataout=0; next idle cycle underflow=0.
- Simultaneous push=pop=1 with top 0x0012 and datain 0x0777 -> dataout=0x0777, count unchanged. On empty with datain 0x0042 -> count=1, dataout=0x0042.
- Interleaved call/return: push 0x0010, push 0x0020, pop, push 0x0030, pop, pop -> dataout sequence 0x0010, 0x0020, 0x0010, 0x0030, 0x0010, 0x0000.
